// File: rtl/window_sweeper_pkg.sv
// Shared types, geometry constants and descriptor normalisation for the
// sliding-window coordinate generator.
package window_sweeper_pkg;

  localparam int IMG_WIDTH  = 41;
  localparam int IMG_HEIGHT = 50;
  localparam int MAX_SWEEP  = 24;
  localparam int MAX_STRIDE = 4;

  localparam int W_X = $clog2(IMG_WIDTH);
  localparam int W_Y = $clog2(IMG_HEIGHT);
  localparam int W_S = $clog2(MAX_SWEEP + 1);
  localparam int W_T = $clog2(MAX_STRIDE + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  typedef struct packed {
    logic [W_X-1:0] x_start;
    logic [W_Y-1:0] y_start;
    logic [W_S-1:0] sweep_x;
    logic [W_S-1:0] sweep_y;
    logic [W_T-1:0] stride_x;
    logic [W_T-1:0] stride_y;
  } sweep_cfg_t;

  // A zero stride would never advance, so it behaves as a unit step;
  // extents beyond the supported window span are limited to it.
  function automatic sweep_cfg_t normalise_cfg(input sweep_cfg_t raw);
    sweep_cfg_t c;
    c = raw;
    if (raw.stride_x == '0) c.stride_x = W_T'(1);
    else                    c.stride_x = raw.stride_x;
    if (raw.stride_y == '0) c.stride_y = W_T'(1);
    else                    c.stride_y = raw.stride_y;
    if (raw.sweep_x > W_S'(MAX_SWEEP)) c.sweep_x = W_S'(MAX_SWEEP);
    else                               c.sweep_x = raw.sweep_x;
    if (raw.sweep_y > W_S'(MAX_SWEEP)) c.sweep_y = W_S'(MAX_SWEEP);
    else                               c.sweep_y = raw.sweep_y;
    return c;
  endfunction

endpackage

// File: rtl/window_sweeper_stride_counter.sv
// One sweep axis: holds the axis start, extent and stride, walks an offset
// from zero in stride steps and flags when the next step leaves either the
// sweep extent or the image.
module stride_counter #(
  parameter int W_V   = 6,   // coordinate width
  parameter int W_O   = 5,   // offset / extent width
  parameter int W_D   = 3,   // stride width
  parameter int BOUND = 40   // largest legal coordinate on this axis
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W_V-1:0] load_start,
  input  logic [W_O-1:0] load_extent,
  input  logic [W_D-1:0] load_stride,
  output logic [W_V-1:0] value,
  output logic           wrap,
  output logic           empty
);

  // Wide enough that start + (offset + stride) can never wrap.
  localparam int W_E = ((W_V > W_O) ? W_V : W_O) + 2;
  localparam logic [W_E-1:0] BOUND_E = W_E'(BOUND);

  logic [W_V-1:0] start;
  logic [W_O-1:0] extent;
  logic [W_D-1:0] stride;
  logic [W_O-1:0] offset;
  logic [W_O:0]   offset_next;
  logic [W_E-1:0] pos_next;
  logic [W_E-1:0] pos_now;

  assign offset_next = {1'b0, offset} + (W_O + 1)'(stride);
  assign pos_next    = W_E'(start) + W_E'(offset_next);
  assign pos_now     = W_E'(start) + W_E'(offset);
  assign value       = pos_now[W_V-1:0];

  // The step after this one is out of the sweep or off the image edge.
  assign wrap  = (offset_next >= {1'b0, extent}) || (pos_next > BOUND_E);

  // Judged on the incoming descriptor so the sweep can be skipped at load.
  assign empty = (load_extent == '0) || (W_E'(load_start) > BOUND_E);

  // Capture axis setup on load; otherwise advance or wrap the offset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start  <= '0;
      extent <= '0;
      stride <= '0;
      offset <= '0;
    end else if (load) begin
      start  <= load_start;
      extent <= load_extent;
      stride <= load_stride;
      offset <= '0;
    end else if (step) begin
      if (wrap) offset <= '0;
      else      offset <= offset_next[W_O-1:0];
    end
  end

endmodule

// File: rtl/window_sweeper.sv
// Sliding-window coordinate generator: takes one sweep descriptor and emits
// the raster of window origins with row/frame markers and a done pulse.
module window_sweeper
  import window_sweeper_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [W_X-1:0] cfg_x_start,
  input  logic [W_Y-1:0] cfg_y_start,
  input  logic [W_S-1:0] cfg_sweep_x,
  input  logic [W_S-1:0] cfg_sweep_y,
  input  logic [W_T-1:0] cfg_stride_x,
  input  logic [W_T-1:0] cfg_stride_y,
  input  logic           abort,
  output logic           addr_valid,
  input  logic           addr_ready,
  output logic [W_X-1:0] x,
  output logic [W_Y-1:0] y,
  output logic           row_last,
  output logic           last,
  output logic           busy,
  output logic           done
);

  state_t     state;
  state_t     state_next;
  logic       done_next;
  logic       load;
  logic       handshake;
  logic       x_wrap;
  logic       y_wrap;
  logic       x_empty;
  logic       y_empty;
  logic       cfg_empty;
  logic       sweep_end;
  sweep_cfg_t cfg_raw;
  sweep_cfg_t cfg_norm;

  assign cfg_raw = '{x_start:  cfg_x_start,
                     y_start:  cfg_y_start,
                     sweep_x:  cfg_sweep_x,
                     sweep_y:  cfg_sweep_y,
                     stride_x: cfg_stride_x,
                     stride_y: cfg_stride_y};
  assign cfg_norm = normalise_cfg(cfg_raw);

  assign cfg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign addr_valid = (state == SWEEP);
  assign handshake  = addr_valid & addr_ready;
  assign cfg_empty  = x_empty | y_empty;
  assign sweep_end  = x_wrap & y_wrap;
  assign row_last   = addr_valid & x_wrap;
  assign last       = addr_valid & sweep_end;

  stride_counter #(
    .W_V   (W_X),
    .W_O   (W_S),
    .W_D   (W_T),
    .BOUND (IMG_WIDTH - 1)
  ) u_x_axis (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (handshake),
    .load_start  (cfg_norm.x_start),
    .load_extent (cfg_norm.sweep_x),
    .load_stride (cfg_norm.stride_x),
    .value       (x),
    .wrap        (x_wrap),
    .empty       (x_empty)
  );

  // The row axis only advances when the column axis wraps.
  stride_counter #(
    .W_V   (W_Y),
    .W_O   (W_S),
    .W_D   (W_T),
    .BOUND (IMG_HEIGHT - 1)
  ) u_y_axis (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (handshake & x_wrap),
    .load_start  (cfg_norm.y_start),
    .load_extent (cfg_norm.sweep_y),
    .load_stride (cfg_norm.stride_y),
    .value       (y),
    .wrap        (y_wrap),
    .empty       (y_empty)
  );

  // Next-state and done decision; abort beats a final handshake.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          load = 1'b1;
          if (cfg_empty) begin
            done_next = 1'b1;
          end else begin
            state_next = SWEEP;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (handshake && sweep_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = SWEEP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and completion-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

endmodule

// File: tb/tb_window_sweeper.sv
// Randomised self-checking bench for window_sweeper against a loop-based
// model of the window raster.
module tb_window_sweeper;
  import window_sweeper_pkg::*;

  localparam int BUDGET = 5000;

  logic           clk;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [W_X-1:0] cfg_x_start;
  logic [W_Y-1:0] cfg_y_start;
  logic [W_S-1:0] cfg_sweep_x;
  logic [W_S-1:0] cfg_sweep_y;
  logic [W_T-1:0] cfg_stride_x;
  logic [W_T-1:0] cfg_stride_y;
  logic           abort;
  logic           addr_valid;
  logic           addr_ready;
  logic [W_X-1:0] x;
  logic [W_Y-1:0] y;
  logic           row_last;
  logic           last;
  logic           busy;
  logic           done;

  window_sweeper dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_x_start  (cfg_x_start),
    .cfg_y_start  (cfg_y_start),
    .cfg_sweep_x  (cfg_sweep_x),
    .cfg_sweep_y  (cfg_sweep_y),
    .cfg_stride_x (cfg_stride_x),
    .cfg_stride_y (cfg_stride_y),
    .abort        (abort),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .x            (x),
    .y            (y),
    .row_last     (row_last),
    .last         (last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit rl;
    bit lst;
  } coord_t;

  coord_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     last_x;
  int     last_y;

  // Count one comparison and report it if the observed value differs.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // Expected raster from the sweep rules, written as two nested loops.
  task automatic build_model(input int xs, input int ys, input int ex, input int ey,
                             input int sx, input int sy);
    coord_t c;
    exp_q.delete();
    if (sx == 0) sx = 1;
    if (sy == 0) sy = 1;
    if (ex > MAX_SWEEP) ex = MAX_SWEEP;
    if (ey > MAX_SWEEP) ey = MAX_SWEEP;
    if (ex == 0 || ey == 0 || xs >= IMG_WIDTH || ys >= IMG_HEIGHT) return;
    for (int oy = 0; oy < ey && ys + oy < IMG_HEIGHT; oy += sy) begin
      for (int ox = 0; ox < ex && xs + ox < IMG_WIDTH; ox += sx) begin
        c.x   = xs + ox;
        c.y   = ys + oy;
        c.rl  = !((ox + sx < ex) && (xs + ox + sx < IMG_WIDTH));
        c.lst = c.rl && !((oy + sy < ey) && (ys + oy + sy < IMG_HEIGHT));
        exp_q.push_back(c);
      end
    end
  endtask

  // Issue one descriptor and consume its coordinates.
  // stop_kind: 0 run to completion, 1 abort after stop_after accepts,
  // 2 asynchronous reset after stop_after accepts.
  task automatic run_sweep(input int xs, input int ys, input int ex, input int ey,
                           input int sx, input int sy, input int ready_pct,
                           input int stop_kind, input int stop_after);
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    build_model(xs, ys, ex, ey, sx, sy);
    cfg_x_start  = W_X'(xs);
    cfg_y_start  = W_Y'(ys);
    cfg_sweep_x  = W_S'(ex);
    cfg_sweep_y  = W_S'(ey);
    cfg_stride_x = W_T'(sx);
    cfg_stride_y = W_T'(sy);
    cfg_valid    = 1'b1;
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;

    if (exp_q.size() == 0) begin
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_valid", 32'(addr_valid), 32'd0);
      @(posedge clk); #1;
      chk("empty_done_drop", 32'(done), 32'd0);
      chk("empty_valid2", 32'(addr_valid), 32'd0);
      return;
    end

    while (exp_q.size() > 0 && cyc < BUDGET) begin
      if (stop_kind != 0 && acc == stop_after) break;
      addr_ready = ($urandom_range(99) < 32'(ready_pct));
      chk("addr_valid", 32'(addr_valid), 32'd1);
      chk("x", 32'(x), 32'(exp_q[0].x));
      chk("y", 32'(y), 32'(exp_q[0].y));
      chk("row_last", 32'(row_last), 32'(exp_q[0].rl));
      chk("last", 32'(last), 32'(exp_q[0].lst));
      chk("done_mid", 32'(done), 32'd0);
      if (addr_ready) begin
        if (last) begin
          last_x = 32'(x);
          last_y = 32'(y);
        end
        void'(exp_q.pop_front());
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("in_budget", 32'(cyc < BUDGET), 32'd1);

    if (stop_kind == 1) begin
      chk("abort_x", 32'(x), 32'(exp_q[0].x));
      chk("abort_y", 32'(y), 32'(exp_q[0].y));
      addr_ready = 1'b1;
      abort      = 1'b1;
      @(posedge clk); #1;
      abort      = 1'b0;
      addr_ready = 1'b0;
      chk("abort_valid", 32'(addr_valid), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("abort_done_later", 32'(done), 32'd0);
    end else if (stop_kind == 2) begin
      addr_ready = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(addr_valid), 32'd0);
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_row_last", 32'(row_last), 32'd0);
      chk("rst_last", 32'(last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      addr_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
    end else begin
      addr_ready = 1'b0;
      chk("end_done", 32'(done), 32'd1);
      chk("end_valid", 32'(addr_valid), 32'd0);
      chk("end_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("end_done_drop", 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    cfg_valid    = 1'b0;
    cfg_x_start  = '0;
    cfg_y_start  = '0;
    cfg_sweep_x  = '0;
    cfg_sweep_y  = '0;
    cfg_stride_x = '0;
    cfg_stride_y = '0;
    abort        = 1'b0;
    addr_ready   = 1'b0;
    last_x       = -1;
    last_y       = -1;
    #2 rst = 1'b0;
    #1;
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("reset_valid", 32'(addr_valid), 32'd0);
    chk("reset_x", 32'(x), 32'd0);
    chk("reset_y", 32'(y), 32'd0);
    chk("reset_row_last", 32'(row_last), 32'd0);
    chk("reset_last", 32'(last), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Abort while idle must be ignored.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_done", 32'(done), 32'd0);

    // Full raster, stride 1x2.
    run_sweep(0, 0, 24, 24, 1, 2, 100, 0, 0);
    chk("t1_last_x", 32'(last_x), 32'd23);
    chk("t1_last_y", 32'(last_y), 32'd22);

    // Clipping at the bottom-right image corner.
    run_sweep(30, 40, 24, 24, 1, 1, 100, 0, 0);
    chk("clip_last_x", 32'(last_x), 32'd40);
    chk("clip_last_y", 32'(last_y), 32'd49);

    // Same raster as the first under heavy backpressure.
    run_sweep(0, 0, 24, 24, 1, 2, 30, 0, 0);

    // Degenerate descriptors.
    run_sweep(5, 5, 0, 4, 1, 1, 100, 0, 0);
    run_sweep(41, 3, 4, 4, 1, 1, 100, 0, 0);
    run_sweep(2, 50, 4, 4, 1, 1, 100, 0, 0);
    run_sweep(5, 7, 3, 1, 0, 0, 100, 0, 0);
    run_sweep(1, 1, 31, 31, 3, 4, 100, 0, 0);

    // Abort mid-sweep, then restart from a new origin.
    run_sweep(0, 0, 24, 24, 1, 1, 100, 1, 5);
    run_sweep(10, 20, 6, 5, 2, 1, 100, 0, 0);

    // Abort coinciding with the final handshake.
    run_sweep(4, 4, 3, 1, 1, 1, 100, 1, 2);

    // Asynchronous reset mid-sweep, then a clean sweep.
    run_sweep(3, 3, 10, 10, 1, 1, 100, 2, 7);
    run_sweep(12, 8, 9, 7, 2, 3, 70, 0, 0);

    // Random descriptors with random backpressure.
    for (int i = 0; i < 14; i++) begin
      run_sweep($urandom_range(0, 45), $urandom_range(0, 55),
                $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(25, 100), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
